// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: FSM states, MEM/WB payload
// layout and the data word returned when a bus access times out.
package mem_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int          TIMEOUT_DEFAULT = 16;
    localparam logic [31:0] BUS_ERR_DATA    = 32'hDEADBEEF;

    typedef struct packed {
        logic        pcsrc;
        logic        reg_write;
        logic        memto_reg;
        logic [31:0] read_data;
        logic [31:0] alu_out;
        logic [3:0]  wa3;
    } mw_t;

    // A bubble keeps the data fields but kills every control that has a side effect.
    function automatic mw_t mw_bubble(input mw_t x);
        mw_t y;
        y           = x;
        y.pcsrc     = 1'b0;
        y.reg_write = 1'b0;
        y.memto_reg = 1'b0;
        return y;
    endfunction

endpackage

// File: rtl/mem_stage_reg_mw.sv
// MEM/WB pipeline register: falling-edge, synchronous reset, and a bubble input
// that zeroes the W-stage controls while the memory stage is stalled.
module reg_mw
    import mem_stage_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic bubble,
    input  mw_t  mw_i,
    output mw_t  mw_o
);

    mw_t mw_d;
    mw_t mw_q;

    always_comb begin
        mw_d = mw_i;
        if (bubble) begin
            mw_d = mw_bubble(mw_i);
        end
    end

    always_ff @(negedge CLK) begin
        if (RESET) begin
            mw_q <= '0;
        end else begin
            mw_q <= mw_d;
        end
    end

    assign mw_o = mw_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: drives a request/ack data bus with a bounded wait, stalls the
// front of the pipeline while an access is outstanding, and feeds MEM/WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PCSrcM,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  WA3M,
    output logic        DReq,
    output logic        DWe,
    output logic [31:0] DAddr,
    output logic [31:0] DWData,
    input  logic [31:0] DRData,
    input  logic        DAck,
    output logic        StallM,
    output logic        PCSrcW,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [3:0]  WA3W,
    output logic        BusErr
);

    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dwe_q, dwe_d;
    logic [31:0]       daddr_q, daddr_d;
    logic [31:0]       dwdata_q, dwdata_d;
    logic              bus_err_q, bus_err_d;

    logic              access;
    logic              in_wait;
    logic              timeout_hit;
    logic              done;
    logic              abort;
    logic              stall;
    mw_t               mw_in;
    mw_t               mw_out;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dwe_d     = dwe_q;
        daddr_d   = daddr_q;
        dwdata_d  = dwdata_q;
        bus_err_d = bus_err_q;

        access      = MemtoRegM | MemWriteM;
        in_wait     = (state_q == ST_WAIT);
        timeout_hit = in_wait && (cnt_q == CNT_LAST);
        done        = in_wait && DAck;
        // An ack in the last wait cycle still completes normally.
        abort       = timeout_hit && !DAck;
        stall       = (!in_wait && access) || (in_wait && !DAck && !timeout_hit);

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    state_d  = ST_WAIT;
                    cnt_d    = '0;
                    dwe_d    = MemWriteM;
                    daddr_d  = ALUResultM;
                    dwdata_d = WriteDataM;
                end
            end
            ST_WAIT: begin
                if (done || abort) begin
                    state_d = ST_IDLE;
                    dwe_d   = 1'b0;
                    if (abort) begin
                        bus_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        mw_in.pcsrc     = PCSrcM;
        mw_in.reg_write = RegWriteM;
        mw_in.memto_reg = MemtoRegM & ~MemWriteM;
        mw_in.read_data = '0;
        mw_in.alu_out   = ALUResultM;
        mw_in.wa3       = WA3M;
        if (done && !dwe_q) begin
            mw_in.read_data = DRData;
        end
        if (abort) begin
            mw_in.pcsrc     = 1'b0;
            mw_in.reg_write = 1'b0;
            mw_in.memto_reg = 1'b0;
            mw_in.read_data = BUS_ERR_DATA;
        end
    end

    always_ff @(negedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dwe_q     <= 1'b0;
            daddr_q   <= '0;
            dwdata_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dwe_q     <= dwe_d;
            daddr_q   <= daddr_d;
            dwdata_q  <= dwdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    reg_mw u_reg_mw (
        .CLK    (CLK),
        .RESET  (RESET),
        .bubble (stall),
        .mw_i   (mw_in),
        .mw_o   (mw_out)
    );

    assign DReq      = in_wait;
    assign DWe       = dwe_q;
    assign DAddr     = daddr_q;
    assign DWData    = dwdata_q;
    assign BusErr    = bus_err_q;
    assign StallM    = stall;
    assign PCSrcW    = mw_out.pcsrc;
    assign RegWriteW = mw_out.reg_write;
    assign MemtoRegW = mw_out.memto_reg;
    assign ReadDataW = mw_out.read_data;
    assign ALUOutW   = mw_out.alu_out;
    assign WA3W      = mw_out.wa3;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios then random instructions, checked
// against a transaction-level model of the stall / bus / write-back rules.
module tb_mem_stage;

    localparam int          TO      = 16;
    localparam logic [31:0] ERR_VAL = 32'hDEADBEEF;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [3:0]  WA3M;
    logic        DReq, DWe;
    logic [31:0] DAddr, DWData, DRData;
    logic        DAck;
    logic        StallM;
    logic        PCSrcW, RegWriteW, MemtoRegW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [3:0]  WA3W;
    logic        BusErr;

    int n_cmp  = 0;
    int n_fail = 0;
    logic bus_err_exp = 1'b0;

    always #5 CLK = ~CLK;

    mem_stage dut (
        .CLK(CLK), .RESET(RESET),
        .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
        .DRData(DRData), .DAck(DAck), .StallM(StallM),
        .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WA3W(WA3W), .BusErr(BusErr)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_nop();
        PCSrcM = 0; RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
        ALUResultM = '0; WriteDataM = '0; WA3M = '0; DAck = 0;
    endtask

    task automatic step();
        @(negedge CLK); #1;
    endtask

    // Non-memory instruction: one-edge pass-through, optional stray DAck ignored.
    task automatic run_alu(input logic p, input logic rw, input logic [31:0] alu,
                           input logic [3:0] wa, input logic stray_ack);
        PCSrcM = p; RegWriteM = rw; MemtoRegM = 0; MemWriteM = 0;
        ALUResultM = alu; WriteDataM = $urandom; WA3M = wa;
        DAck = stray_ack; DRData = $urandom;
        @(posedge CLK);
        chk1("alu_stall", StallM, 1'b0);
        chk1("alu_dreq", DReq, 1'b0);
        step();
        drive_nop();
        @(posedge CLK);
        chk1("alu_pcsrcw", PCSrcW, p);
        chk1("alu_regwritew", RegWriteW, rw);
        chk1("alu_memtoregw", MemtoRegW, 1'b0);
        chk32("alu_aluoutw", ALUOutW, alu);
        chk32("alu_wa3w", 32'(WA3W), 32'(wa));
        chk1("alu_dreq_after", DReq, 1'b0);
        $display("alu  p=%0b rw=%0b alu=%h wa=%0d ack=%0b", p, rw, alu, wa, stray_ack);
        step();
    endtask

    // Memory instruction; ack_k is the WAIT cycle (1-based) carrying DAck, 0 for none.
    task automatic run_mem(input logic p, input logic rw, input logic m2r, input logic mw,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa,
                           input int ack_k, input logic [31:0] rdata);
        bit fin = 0;
        bit aborted = 0;
        int waits = 0;
        PCSrcM = p; RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
        ALUResultM = alu; WriteDataM = wd; WA3M = wa; DAck = 0;
        @(posedge CLK);
        chk1("mem_idle_stall", StallM, 1'b1);
        chk1("mem_idle_dreq", DReq, 1'b0);
        step();
        for (int k = 1; k <= TO && !fin; k++) begin
            DAck   = (k == ack_k);
            DRData = (k == ack_k) ? rdata : $urandom;
            @(posedge CLK);
            chk1("wait_bubble_pcsrc", PCSrcW, 1'b0);
            chk1("wait_bubble_regwrite", RegWriteW, 1'b0);
            chk1("wait_bubble_memtoreg", MemtoRegW, 1'b0);
            chk1("wait_dreq", DReq, 1'b1);
            chk32("wait_daddr", DAddr, alu);
            chk32("wait_dwdata", DWData, wd);
            chk1("wait_dwe", DWe, mw);
            chk1("wait_stall", StallM, !((k == ack_k) || (k == TO)));
            chk1("wait_buserr", BusErr, bus_err_exp);
            waits = k;
            if (k == ack_k) fin = 1;
            else if (k == TO) begin fin = 1; aborted = 1; end
            step();
        end
        drive_nop();
        if (aborted) bus_err_exp = 1'b1;
        @(posedge CLK);
        if (aborted) begin
            chk1("abort_pcsrcw", PCSrcW, 1'b0);
            chk1("abort_regwritew", RegWriteW, 1'b0);
            chk1("abort_memtoregw", MemtoRegW, 1'b0);
            chk32("abort_readdataw", ReadDataW, ERR_VAL);
        end else begin
            chk1("done_pcsrcw", PCSrcW, p);
            chk1("done_regwritew", RegWriteW, rw);
            chk1("done_memtoregw", MemtoRegW, m2r && !mw);
            chk32("done_readdataw", ReadDataW, mw ? 32'h0 : rdata);
            chk32("done_aluoutw", ALUOutW, alu);
            chk32("done_wa3w", 32'(WA3W), 32'(wa));
        end
        chk1("after_dreq", DReq, 1'b0);
        chk1("after_buserr", BusErr, bus_err_exp);
        $display("mem  %s addr=%h waits=%0d %s busErr=%0b", mw ? "WR" : "RD", alu, waits,
                 aborted ? "abort" : "done", bus_err_exp);
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_dreq"}, DReq, 1'b0);
        chk1({tag, "_dwe"}, DWe, 1'b0);
        chk32({tag, "_daddr"}, DAddr, 32'h0);
        chk32({tag, "_dwdata"}, DWData, 32'h0);
        chk1({tag, "_buserr"}, BusErr, 1'b0);
        chk1({tag, "_pcsrcw"}, PCSrcW, 1'b0);
        chk1({tag, "_regwritew"}, RegWriteW, 1'b0);
        chk1({tag, "_memtoregw"}, MemtoRegW, 1'b0);
        chk32({tag, "_readdataw"}, ReadDataW, 32'h0);
        chk32({tag, "_aluoutw"}, ALUOutW, 32'h0);
        chk32({tag, "_wa3w"}, 32'(WA3W), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1; DRData = '0;
        drive_nop();
        step(); step();
        @(posedge CLK);
        chk_all_zero("reset");
        chk1("reset_stall", StallM, 1'b0);
        $display("reset checked");
        RESET = 0;
        step();

        // ALU op, load with ack on 3rd wait, store with ack on 1st wait.
        run_alu(1'b0, 1'b1, 32'h10, 4'd3, 1'b0);
        run_mem(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'd5, 3, 32'hCAFEF00D);
        run_mem(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h55, 4'd0, 1, 32'h0);
        // Both MemtoReg and MemWrite set: treated as a write.
        run_mem(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 32'h1234, 4'd7, 2, 32'h99);
        // Ack coinciding with the last wait cycle completes normally.
        run_mem(1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 4'd2, TO, 32'h600DF00D);
        // Timeout, then a normal load with the sticky flag still set.
        run_mem(1'b1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 4'd4, 0, 32'h0);
        run_mem(1'b0, 1'b1, 1'b1, 1'b0, 32'h504, 32'h0, 4'd4, 2, 32'h0BADCAFE);
        run_alu(1'b1, 1'b1, 32'hABCD, 4'd9, 1'b1);

        // Reset during the 2nd WAIT cycle, then a late DAck.
        PCSrcM = 0; RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0;
        ALUResultM = 32'h700; WriteDataM = '0; WA3M = 4'd6;
        step(); step();
        @(posedge CLK);
        chk1("rst_wait_dreq_before", DReq, 1'b1);
        RESET = 1;
        drive_nop();
        step();
        RESET = 0;
        @(posedge CLK);
        chk_all_zero("rst_wait");
        bus_err_exp = 1'b0;
        step();
        DAck = 1; DRData = 32'h11111111;
        @(posedge CLK);
        chk1("late_ack_stall", StallM, 1'b0);
        step();
        DAck = 0;
        @(posedge CLK);
        chk_all_zero("late_ack");
        $display("reset during wait checked");
        step();

        for (int i = 0; i < 40; i++) begin
            int kind = int'($urandom_range(0, 2));
            logic [3:0] wa = 4'($urandom);
            if (kind == 0) begin
                run_alu(1'($urandom), 1'($urandom), $urandom, wa, 1'($urandom));
            end else begin
                int ack = int'($urandom_range(0, TO + 2));
                if (ack > TO) ack = 0;
                run_mem(1'($urandom), 1'($urandom), (kind == 1) ? 1'b1 : 1'($urandom),
                        (kind == 2) ? 1'b1 : 1'b0, $urandom, $urandom, wa, ack, $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: CLK  in  1  single clock; all state updates on the falling edge, matching the pipeline registers.
REQ-002 SHALL have ports: RESET  in  1  synchronous, active-high reset, sampled on the falling edge of CLK.
REQ-003 SHALL have ports: PCSrcM, RegWriteM, MemtoRegM, MemWriteM  in  1 each  M-stage controls from the EX/MEM register.
REQ-004 SHALL have ports: ALUResultM  in  32  address / ALU value; WriteDataM  in  32  store data; WA3M  in  4  destination register.
REQ-005 SHALL have ports: DReq  out  1  bus request; DWe  out  1  write strobe; DAddr  out  32; DWData  out  32.
REQ-006 SHALL have ports: DRData  in  32  read data; DAck  in  1  one-cycle completion pulse.
REQ-007 SHALL have ports: StallM  out  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
REQ-008 SHALL have ports: PCSrcW, RegWriteW, MemtoRegW  out  1 each  W-stage controls.
REQ-009 SHALL have ports: ReadDataW  out  32; ALUOutW  out  32; WA3W  out  4  W-stage data.
REQ-010 SHALL have ports: BusErr  out  1  sticky timeout flag.
REQ-011 SHALL use parameter TIMEOUT, default 16, as the maximum number of WAIT cycles before abort.

Function
REQ-012 SHALL define access = MemtoRegM | MemWriteM; if both are set, the access SHALL be treated as a write and MemtoRegW SHALL be forced to 0.
REQ-013 SHALL implement FSM states IDLE and WAIT.
REQ-014 In IDLE with access=1, the FSM SHALL move to WAIT on the next edge and latch DAddr=ALUResultM, DWData=WriteDataM, DWe=MemWriteM.
REQ-015 In IDLE with access=0, the FSM SHALL stay in IDLE.
REQ-016 In WAIT with DAck=1, the FSM SHALL capture DRData and return to IDLE.
REQ-017 In WAIT with the timeout counter equal to TIMEOUT-1 and DAck=0, the FSM SHALL abort to IDLE.
REQ-018 DReq SHALL be 1 exactly while in WAIT; DAddr, DWData and DWe SHALL remain stable throughout WAIT.
REQ-019 StallM SHALL be combinational: (IDLE & access) | (WAIT & ~DAck & ~timeout_hit).
REQ-020 The timeout counter (4 bits for default TIMEOUT) SHALL clear on entry to WAIT and increment each WAIT cycle without DAck; it SHALL never wrap.
REQ-021 Non-memory instructions SHALL pass to the W outputs with 1-edge latency.
REQ-022 A memory instruction SHALL reach the W outputs on the edge ending the cycle in which DAck (or abort) occurs.
REQ-023 While StallM=1, the MEM/WB register SHALL load a bubble: PCSrcW=RegWriteW=MemtoRegW=0.
REQ-024 On read completion: ReadDataW=DRData; ALUOutW=ALUResultM; controls and WA3W SHALL pass through.
REQ-025 On write completion: ReadDataW=0 and all controls SHALL pass through.
REQ-026 On abort: RegWriteW=0, MemtoRegW=0 and PCSrcW=0; ReadDataW SHALL equal BUS_ERR_DATA (32'hDEADBEEF); BusErr SHALL set and remain 1 until reset.
REQ-027 A DAck arriving in IDLE SHALL be ignored.
REQ-028 A DAck arriving in the same cycle as timeout_hit SHALL win, giving normal completion.

Reset
REQ-029 On RESET: state=IDLE, counter=0, BusErr=0, DReq=0, DWe=0, DAddr=0, DWData=0.
REQ-030 On RESET: all W outputs SHALL be 0.
REQ-031 RESET asserted during WAIT SHALL abandon the access (DReq low after that edge) without setting BusErr; any late DAck SHALL be ignored.

Structure
REQ-032 Package mem_stage_pkg SHALL hold the state enum, TIMEOUT default and BUS_ERR_DATA.
REQ-033 The MEM/WB register SHALL be a sub-module reg_mw (falling-edge, bubble input, synchronous reset).
REQ-034 The FSM, counter and bus drive SHALL reside in mem_stage.

Verification
REQ-035 ALU op (RegWriteM=1, ALUResultM=0x10, WA3M=3) -> next edge RegWriteW=1, ALUOutW=0x10, WA3W=3, StallM=0, DReq=0.
REQ-036 Load at 0x100 with DAck on the 3rd WAIT cycle, DRData=0xCAFEF00D -> StallM high for 3 cycles, 3 bubbles in W, then ReadDataW=0xCAFEF00D, MemtoRegW=1.
REQ-037 Store 0x55 to 0x200 with DAck on the 1st WAIT cycle -> DWe=1, DAddr=0x200, DWData=0x55 held during WAIT; RegWriteW=0 afterward.
REQ-038 Load with no DAck -> after 16 WAIT cycles: abort, BusErr=1, RegWriteW=0, ReadDataW=0xDEADBEEF; next load completes normally with BusErr still 1.
REQ-039 RESET during the 2nd WAIT cycle, then DAck -> state IDLE, DReq=0, BusErr=0, W outputs 0, DAck ignored.
REQ-040 MemtoRegM=MemWriteM=1 -> write issued (DWe=1), MemtoRegW=0 on completion.
